// File: rtl/game_input_conditioner.sv
// game_input_conditioner
//   Front end for the memory-game controller. Conditions every control input
//   before the controller sees it.
//   Clk, Rst          : system clock, synchronous active-low reset
//   gameKey_n         : raw game-start key (async, low = pressed)
//   playerKey_n       : raw player-enter key (async, low = pressed)
//   sw[3:0]           : raw player switches (async)
//   enableTimer       : pacing-timer enable from the controller
//   gameButton_in     : one-cycle pulse per accepted game-key press
//   p_button          : one-cycle pulse per accepted player-key press
//   p_input[3:0]      : synchronised switch value
//   randNum[3:0]      : random value latched on game press, never 0 once loaded
//   pulse1sTimer      : one-cycle pacing pulse every PULSE_PERIOD enabled cycles

// key_debounce
//   One key lane: 2-flop synchroniser plus a four-state debounce FSM.
//   Clk, Rst : clock, synchronous active-low reset
//   key_n    : raw active-low key
//   press    : registered one-cycle pulse on an accepted press
//   A change of state needs CYCLES consecutive synchronised samples of the new
//   level (CYCLES >= 2).
module key_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]    sync;
  logic          key_s, press_nxt;

  assign key_s   = sync[1];
  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync  <= 2'b11;
      state <= RELEASED;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  // The sample that leaves a stable state counts as the first of CYCLES, so
  // the lane commits when the incremented count reaches CYCLES-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    unique case (state)
      RELEASED: if (!key_s) begin
        state_nxt = PRESS_WAIT;
        cnt_nxt   = '0;
      end
      PRESS_WAIT: begin
        if (key_s) state_nxt = RELEASED;
        else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == LAST) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
          end
        end
      end
      PRESSED: if (key_s) begin
        state_nxt = RELEASE_WAIT;
        cnt_nxt   = '0;
      end
      RELEASE_WAIT: begin
        if (!key_s) state_nxt = PRESSED;
        else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == LAST) state_nxt = RELEASED;
        end
      end
      default: state_nxt = RELEASED;
    endcase
  end
endmodule

module game_input_conditioner #(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          PULSE_PERIOD    = 50000000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       gameKey_n,
  input  logic       playerKey_n,
  input  logic [3:0] sw,
  input  logic       enableTimer,
  output logic       gameButton_in,
  output logic       p_button,
  output logic [3:0] p_input,
  output logic [3:0] randNum,
  output logic       pulse1sTimer
);
  localparam int          NUM_KEYS = 2;
  localparam logic [15:0] MASK     = 16'hB400;
  localparam int          TW       = (PULSE_PERIOD > 1) ? $clog2(PULSE_PERIOD) : 1;
  localparam logic [TW-1:0] TLAST  = TW'(PULSE_PERIOD - 1);

  // Key lanes: [0] game start, [1] player enter.
  logic [NUM_KEYS-1:0] key_n, press;
  assign key_n = {playerKey_n, gameKey_n};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .Clk   (Clk),
      .Rst   (Rst),
      .key_n (key_n[g]),
      .press (press[g])
    );
  end

  assign gameButton_in = press[0];
  assign p_button      = press[1];

  // Switches: two sync stages, then an output register.
  logic [3:0] sw_s1, sw_s2;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      p_input <= '0;
    end else begin
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      p_input <= sw_s2;
    end
  end

  // Free-running Galois LFSR. Zero is a lock-up state, so it self-heals.
  logic [15:0] lfsr;
  always_ff @(posedge Clk) begin
    if (!Rst)                lfsr <= LFSR_SEED;
    else if (lfsr == 16'h0)  lfsr <= LFSR_SEED;
    else                     lfsr <= (lfsr >> 1) ^ (lfsr[0] ? MASK : 16'h0);
  end

  // Latch on the game pulse; substitute 1 so the controller never sees 0.
  always_ff @(posedge Clk) begin
    if (!Rst)               randNum <= '0;
    else if (gameButton_in) randNum <= (lfsr[3:0] == 4'd0) ? 4'd1 : lfsr[3:0];
  end

  // Pacing timer: clears whenever disabled so each enable starts a full period.
  logic [TW-1:0] tcnt;
  always_ff @(posedge Clk) begin
    if (!Rst || !enableTimer) begin
      tcnt         <= '0;
      pulse1sTimer <= 1'b0;
    end else if (tcnt == TLAST) begin
      tcnt         <= '0;
      pulse1sTimer <= 1'b1;
    end else begin
      tcnt         <= tcnt + TW'(1);
      pulse1sTimer <= 1'b0;
    end
  end
endmodule

// File: tb/tb_game_input_conditioner.sv
module tb_game_input_conditioner;
  localparam int          D    = 4;
  localparam int          P    = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       Clk = 1'b0;
  logic       Rst, gameKey_n, playerKey_n, enableTimer;
  logic [3:0] sw;
  logic       gameButton_in, p_button, pulse1sTimer;
  logic [3:0] p_input, randNum;

  game_input_conditioner #(.DEBOUNCE_CYCLES(D), .PULSE_PERIOD(P), .LFSR_SEED(SEED)) dut (
    .Clk(Clk), .Rst(Rst), .gameKey_n(gameKey_n), .playerKey_n(playerKey_n), .sw(sw),
    .enableTimer(enableTimer), .gameButton_in(gameButton_in), .p_button(p_button),
    .p_input(p_input), .randNum(randNum), .pulse1sTimer(pulse1sTimer)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  int cyc_n = 0;
  int gb_cnt = 0, pb_cnt = 0, gb_at = -1;
  int tp_q[$];

  // Reference model: keys accept a new level after D consecutive synced
  // samples of it; sync is a 2-sample delay line; switches see a 3-edge delay.
  bit          kq0[$], kq1[$];
  logic [3:0]  swq[$];
  int          m_run[2];
  bit          m_pressed[2], m_pulse[2];
  logic [15:0] m_lfsr;
  logic [3:0]  m_rand, m_pin;
  int          m_tn;
  bit          m_tp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    if (v == 16'h0) return SEED;
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0);
  endfunction

  task automatic model_reset();
    kq0 = '{1'b1, 1'b1};
    kq1 = '{1'b1, 1'b1};
    swq = '{4'h0, 4'h0};
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_pressed[k] = 0; m_pulse[k] = 0;
    end
    m_lfsr = SEED; m_rand = 0; m_pin = 0; m_tn = 0; m_tp = 0;
  endtask

  task automatic step();
    bit raw0, raw1, r, en, seen, target;
    logic [3:0] raw_sw;
    raw0 = gameKey_n; raw1 = playerKey_n; raw_sw = sw; r = Rst; en = enableTimer;
    @(posedge Clk);
    cyc_n++;
    if (!r) model_reset();
    else begin
      if (m_pulse[0]) m_rand = (m_lfsr[3:0] == 4'd0) ? 4'd1 : m_lfsr[3:0];
      m_lfsr = lfsr_next(m_lfsr);
      m_pin = swq.pop_front();
      swq.push_back(raw_sw);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin seen = kq0.pop_front(); kq0.push_back(raw0); end
        else        begin seen = kq1.pop_front(); kq1.push_back(raw1); end
        target = !seen;
        m_pulse[k] = 0;
        if (target != m_pressed[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_pressed[k] = target;
            m_run[k] = 0;
            m_pulse[k] = target;
          end
        end else m_run[k] = 0;
      end
      if (en) begin m_tn++; m_tp = (m_tn % P == 0); end
      else    begin m_tn = 0; m_tp = 0; end
    end
    #1;
    chk("gameButton_in", 32'(gameButton_in), 32'(m_pulse[0]));
    chk("p_button", 32'(p_button), 32'(m_pulse[1]));
    chk("p_input", 32'(p_input), 32'(m_pin));
    chk("randNum", 32'(randNum), 32'(m_rand));
    chk("pulse1sTimer", 32'(pulse1sTimer), 32'(m_tp));
    if (gameButton_in) begin gb_cnt++; gb_at = cyc_n; end
    if (p_button) pb_cnt++;
    if (pulse1sTimer) tp_q.push_back(cyc_n);
  endtask

  initial begin
    int e0;
    bit hit;
    Rst = 0; gameKey_n = 1; playerKey_n = 1; sw = 0; enableTimer = 0;
    model_reset();
    repeat (2) step();
    chk("rst_lfsr", 32'(dut.lfsr), 32'(SEED));
    Rst = 1;
    repeat (3) step();

    // 1: held game key gives one pulse 6 edges after the drop, none on release
    gb_cnt = 0; gameKey_n = 0; e0 = cyc_n;
    repeat (20) step();
    chk("t1_count", 32'(gb_cnt), 32'd1);
    chk("t1_latency", 32'(gb_at - e0), 32'd6);
    chk("t1_rand_nonzero", 32'(randNum != 4'd0), 32'd1);
    gameKey_n = 1;
    repeat (10) step();
    chk("t1_no_release_pulse", 32'(gb_cnt), 32'd1);

    // 2: short glitch ignored, long press accepted once
    pb_cnt = 0; playerKey_n = 0;
    repeat (3) step();
    playerKey_n = 1;
    repeat (8) step();
    chk("t2_glitch", 32'(pb_cnt), 32'd0);
    playerKey_n = 0;
    repeat (6) step();
    playerKey_n = 1;
    repeat (8) step();
    chk("t2_press", 32'(pb_cnt), 32'd1);

    // 3: pacing pulses on enabled edges 10,20,30; restart after re-enable
    tp_q.delete(); enableTimer = 1; e0 = cyc_n;
    repeat (35) step();
    chk("t3_npulses", 32'(tp_q.size()), 32'd3);
    for (int i = 0; i < tp_q.size() && i < 3; i++)
      chk("t3_pulse_at", 32'(tp_q[i] - e0), 32'((i + 1) * P));
    enableTimer = 0;
    repeat (2) step();
    tp_q.delete(); enableTimer = 1; e0 = cyc_n;
    repeat (12) step();
    chk("t3_restart_n", 32'(tp_q.size()), 32'd1);
    if (tp_q.size() > 0) chk("t3_restart_at", 32'(tp_q[0] - e0), 32'(P));
    enableTimer = 0;

    // 4: switch latency of 3 edges, single-cycle value still propagates
    sw = 4'h0; repeat (4) step();
    sw = 4'hB; repeat (2) step();
    chk("t4_not_yet", 32'(p_input), 32'h0);
    step();
    chk("t4_latency", 32'(p_input), 32'hB);
    sw = 4'h5; step();
    sw = 4'hB; step(); step();
    chk("t4_one_cycle", 32'(p_input), 32'h5);
    step();
    chk("t4_back", 32'(p_input), 32'hB);

    // 5: LFSR lock-up recovery and zero-nibble substitution
    dut.lfsr = 16'h0; m_lfsr = 16'h0;
    step();
    chk("t5_reload", 32'(dut.lfsr), 32'(SEED));
    gameKey_n = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (gameButton_in) begin
        dut.lfsr = 16'h1230; m_lfsr = 16'h1230; hit = 1;
      end
    end
    chk("t5_press_seen", 32'(hit), 32'd1);
    step();
    chk("t5_rand_one", 32'(randNum), 32'd1);
    gameKey_n = 1;
    repeat (8) step();

    // 6: reset mid-debounce and mid-count
    enableTimer = 1;
    repeat (2) step();
    gameKey_n = 0;
    repeat (5) step();
    Rst = 0; step();
    chk("t6_rst_outs", 32'({gameButton_in, p_button, p_input, randNum, pulse1sTimer}), 32'd0);
    Rst = 1; gb_cnt = 0; tp_q.delete(); e0 = cyc_n;
    repeat (12) step();
    chk("t6_press_count", 32'(gb_cnt), 32'd1);
    chk("t6_press_latency", 32'(gb_at - e0), 32'd6);
    chk("t6_timer_n", 32'(tp_q.size()), 32'd1);
    if (tp_q.size() > 0) chk("t6_timer_at", 32'(tp_q[0] - e0), 32'(P));
    gameKey_n = 1; enableTimer = 0;
    repeat (8) step();

    // Random phase: bursty keys, random switches/enable, occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) gameKey_n = ~gameKey_n;
      if ($urandom_range(5) == 0) playerKey_n = ~playerKey_n;
      if ($urandom_range(19) == 0) enableTimer = ~enableTimer;
      if ($urandom_range(3) == 0) sw = 4'($urandom);
      Rst = ($urandom_range(149) != 0);
      step();
    end
    Rst = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
